// File: rtl/counter_pkg.sv
// Shared constants for the 4-bit up/down/load counter.
// Mode encoding and data width live here so counter and counter_next agree.
package counter_pkg;

   localparam int WIDTH = 4;

   typedef enum logic [1:0] {
      MODE_UP1  = 2'b00,
      MODE_DN1  = 2'b01,
      MODE_UP3  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] Q_MAX = '1;
   localparam logic [WIDTH-1:0] Q_MIN = '0;

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the counter: next Q, next rco, next load.
// COUNTER_SAT_EN selects clamping at 15/0 instead of modulo-16 wrap.
module counter_next
   import counter_pkg::*;
(
   input  logic [WIDTH-1:0] q,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next,
   output logic             rco_next,
   output logic             load_next
);

   logic [WIDTH:0] sum;
   logic           arith;
   logic           down;

   always_comb begin
      q_next    = q;
      rco_next  = 1'b0;
      load_next = 1'b0;
      sum       = '0;
      arith     = 1'b0;
      down      = 1'b0;
      if (enable) begin
         // An unknown mode matches no item and falls to the hold default.
         case (mode_e'(mode))
            MODE_UP1: begin
               sum   = {1'b0, q} + (WIDTH+1)'(1);
               arith = 1'b1;
            end
            MODE_DN1: begin
               sum   = {1'b0, q} - (WIDTH+1)'(1);
               arith = 1'b1;
               down  = 1'b1;
            end
            MODE_UP3: begin
               sum   = {1'b0, q} + (WIDTH+1)'(3);
               arith = 1'b1;
            end
            MODE_LOAD: begin
               q_next    = d;
               load_next = 1'b1;
            end
            default: begin
               q_next = q;
            end
         endcase

         if (arith) begin
            // sum[WIDTH] is the carry (up) or borrow (down) out of bit 3.
            rco_next = sum[WIDTH];
`ifdef COUNTER_SAT_EN
            if (sum[WIDTH]) begin
               q_next = down ? Q_MIN : Q_MAX;
            end else begin
               q_next = sum[WIDTH-1:0];
            end
`else
            q_next = sum[WIDTH-1:0];
`endif
         end
      end
   end

endmodule

// File: rtl/counter.sv
// 4-bit counter top: output registers and async active-low reset only.
// Build option: COUNTER_SAT_EN (saturating instead of wrapping count).
module counter
   import counter_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             load,
   output logic             rco
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             load_q, load_d;
   logic             rco_q, rco_d;

   counter_next u_next (
      .q         (q_q),
      .enable    (enable),
      .mode      (mode),
      .d         (D),
      .q_next    (q_d),
      .rco_next  (rco_d),
      .load_next (load_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q    <= '0;
         load_q <= 1'b0;
         rco_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         load_q <= load_d;
         rco_q  <= rco_d;
      end
   end

   assign Q    = q_q;
   assign load = load_q;
   assign rco  = rco_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed corner cases plus randomized
// stimulus against an arithmetic reference model.
module tb_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] D;
   logic [3:0] Q;
   logic       load;
   logic       rco;

   int n_tests = 0;
   int n_fail  = 0;

   int m_q    = 0;
   int m_load = 0;
   int m_rco  = 0;

   counter dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .mode   (mode),
      .D      (D),
      .Q      (Q),
      .load   (load),
      .rco    (rco)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: next state from the operation rules in plain integers.
   task automatic model_step(input int en, input int md, input int dd);
      int n;
      m_load = 0;
      m_rco  = 0;
      if (en == 0) return;
      case (md)
         0: n = m_q + 1;
         1: n = m_q - 1;
         2: n = m_q + 3;
         default: begin
            m_q    = dd;
            m_load = 1;
            return;
         end
      endcase
      if (n > 15 || n < 0) begin
         m_rco = 1;
`ifdef COUNTER_SAT_EN
         n = (n > 15) ? 15 : 0;
`else
         n = (n + 16) % 16;
`endif
      end
      m_q = n;
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_q"},    int'(Q),    m_q);
      check({tag, "_load"}, int'(load), m_load);
      check({tag, "_rco"},  int'(rco),  m_rco);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
   task automatic step(input logic en, input logic [1:0] md, input logic [3:0] dd,
                       input string tag);
      enable = en;
      mode   = md;
      D      = dd;
      @(posedge clk);
      #1;
      model_step(int'(en), int'(md), int'(dd));
      compare_model(tag);
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      m_q = 0; m_load = 0; m_rco = 0;
      check({tag, "_q"},    int'(Q),    0);
      check({tag, "_load"}, int'(load), 0);
      check({tag, "_rco"},  int'(rco),  0);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      mode   = 2'b00;
      D      = 4'h0;
      #1;
      check("por_q",    int'(Q),    0);
      check("por_load", int'(load), 0);
      check("por_rco",  int'(rco),  0);
      #1;
      reset = 1'b1;

      // Reset mid-count from Q=9, no clock edge needed.
      step(1'b1, 2'b11, 4'd8, "ld8");
      step(1'b1, 2'b00, 4'd0, "to9");
      check("pre_rst_q", int'(Q), 9);
      async_reset("rst_mid");
      step(1'b1, 2'b00, 4'd0, "post_rst");
      check("post_rst_q1", int'(Q), 1);

`ifndef COUNTER_SAT_EN
      step(1'b1, 2'b11, 4'd14, "ld14");
      step(1'b1, 2'b00, 4'd0, "up_a");
      check("upwrap_15", int'(Q), 15); check("upwrap_15_rco", int'(rco), 0);
      step(1'b1, 2'b00, 4'd0, "up_b");
      check("upwrap_0", int'(Q), 0);   check("upwrap_0_rco", int'(rco), 1);
      step(1'b1, 2'b00, 4'd0, "up_c");
      check("upwrap_1_rco", int'(rco), 0);

      step(1'b1, 2'b11, 4'd1, "ld1");
      step(1'b1, 2'b01, 4'd0, "dn_a");
      check("dnwrap_0", int'(Q), 0);   check("dnwrap_0_rco", int'(rco), 0);
      step(1'b1, 2'b01, 4'd0, "dn_b");
      check("dnwrap_15", int'(Q), 15); check("dnwrap_15_rco", int'(rco), 1);

      step(1'b1, 2'b11, 4'd12, "ld12");
      step(1'b1, 2'b10, 4'd0, "up3_a");
      check("up3_15", int'(Q), 15); check("up3_15_rco", int'(rco), 0);
      step(1'b1, 2'b10, 4'd0, "up3_b");
      check("up3_2", int'(Q), 2);   check("up3_2_rco", int'(rco), 1);
`else
      step(1'b1, 2'b11, 4'd15, "ld15");
      step(1'b1, 2'b00, 4'd0, "sat_up_a");
      check("satup_q_a", int'(Q), 15); check("satup_rco_a", int'(rco), 1);
      step(1'b1, 2'b00, 4'd0, "sat_up_b");
      check("satup_q_b", int'(Q), 15); check("satup_rco_b", int'(rco), 1);
      step(1'b1, 2'b11, 4'd0, "ld0");
      step(1'b1, 2'b01, 4'd0, "sat_dn");
      check("satdn_q", int'(Q), 0);    check("satdn_rco", int'(rco), 1);
      step(1'b1, 2'b11, 4'd13, "ld13");
      step(1'b1, 2'b10, 4'd0, "sat_up3");
      check("satup3_q", int'(Q), 15);  check("satup3_rco", int'(rco), 1);
`endif

      // Load then hold.
      step(1'b1, 2'b11, 4'hA, "ldA");
      check("ldA_q", int'(Q), 10); check("ldA_load", int'(load), 1);
      step(1'b0, 2'b11, 4'h3, "holdA");
      check("holdA_q", int'(Q), 10); check("holdA_load", int'(load), 0);
      step(1'b0, 2'b00, 4'h3, "holdA2");
      check("holdA2_q", int'(Q), 10);

      // Randomized run with occasional mid-operation reset.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset("rnd_rst");
         end else begin
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 "rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
